// File: rtl/axil_to_wb_bridge.sv
// AXI4-Lite target to Wishbone classic master bridge. One transaction is in flight at a time.
// Each Wishbone access is bounded by a timeout, and non-OKAY responses pulse bridge_err_o.
module axil_to_wb_bridge #(
  parameter int ADDR_BITS = 18,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [ADDR_BITS-1:0]   s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DATA_BITS-1:0]   s_axi_wdata,
  input  logic [DATA_BITS/8-1:0] s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ADDR_BITS-1:0]   s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [DATA_BITS-1:0]   s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [ADDR_BITS-1:0]   wb_adr_o,
  output logic [DATA_BITS-1:0]   wb_dat_o,
  output logic [DATA_BITS/8-1:0] wb_sel_o,
  input  logic [DATA_BITS-1:0]   wb_dat_i,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  input  logic                   wb_rty_i,
  output logic                   bridge_err_o
);

  localparam int SEL_BITS = DATA_BITS / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WB_WRITE, WB_READ, WRESP, RRESP} state_t;

  state_t state_q, state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic rr_q, rr_d;
  logic [ADDR_BITS-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SEL_BITS-1:0]  wstrb_q, wstrb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d, berr_q, berr_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;

  logic idle, aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig, grant_wr, grant_rd;
  logic timeout_hit, wb_done;
  logic [1:0] term_resp;

  assign idle    = (state_q == IDLE);
  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign wr_elig = aw_held_q && w_held_q;
  assign rd_elig = ar_held_q;
  // rr_q == 0 favours the write when both sides are waiting
  assign grant_wr = idle && wr_elig && (!rd_elig || !rr_q);
  assign grant_rd = idle && rd_elig && (!wr_elig || rr_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TMO_CNT);

  // Termination priority: err > rty > ack > timeout
  always_comb begin
    wb_done   = 1'b0;
    term_resp = RESP_OKAY;
    if (wb_err_i || wb_rty_i) begin
      wb_done   = 1'b1;
      term_resp = RESP_SLVERR;
    end else if (wb_ack_i) begin
      wb_done = 1'b1;
    end else if (timeout_hit) begin
      wb_done   = 1'b1;
      term_resp = RESP_DECERR;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      ar_held_q <= ar_held_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      berr_q    <= berr_d;
    end
  end

  // Captured address/data only matter while the matching held flag is set
  always_ff @(posedge wb_clk_i) begin
    awaddr_q <= awaddr_d;
    araddr_q <= araddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_wr)      state_d = WB_WRITE;
        else if (grant_rd) state_d = WB_READ;
      end
      WB_WRITE: if (wb_done) state_d = WRESP;
      WB_READ:  if (wb_done) state_d = RRESP;
      WRESP:    if (s_axi_bready) state_d = IDLE;
      RRESP:    if (s_axi_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    ar_held_d = ar_held_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rr_d      = rr_q;
    cnt_d     = idle ? '0 : cnt_q + CNT_W'(1);
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    berr_d    = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end
    if (ar_hs) begin
      ar_held_d = 1'b1;
      araddr_d  = s_axi_araddr;
    end
    if (grant_wr || grant_rd) rr_d = !rr_q;

    if (state_q == WB_WRITE && wb_done) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = term_resp;
      berr_d    = (term_resp != RESP_OKAY);
    end
    if (state_q == WB_READ && wb_done) begin
      ar_held_d = 1'b0;
      rvalid_d  = 1'b1;
      rresp_d   = term_resp;
      rdata_d   = (term_resp == RESP_OKAY) ? wb_dat_i : '0;
      berr_d    = (term_resp != RESP_OKAY);
    end
    if (state_q == WRESP && s_axi_bready) bvalid_d = 1'b0;
    if (state_q == RRESP && s_axi_rready) rvalid_d = 1'b0;
  end

  always_comb begin
    s_axi_awready = idle && !aw_held_q && !wb_rst_i;
    s_axi_wready  = idle && !w_held_q && !wb_rst_i;
    s_axi_arready = idle && !ar_held_q && !wb_rst_i;
    s_axi_bvalid  = bvalid_q;
    s_axi_bresp   = bresp_q;
    s_axi_rvalid  = rvalid_q;
    s_axi_rresp   = rresp_q;
    s_axi_rdata   = rdata_q;
    wb_cyc_o      = (state_q == WB_WRITE) || (state_q == WB_READ);
    wb_stb_o      = wb_cyc_o;
    wb_we_o       = (state_q == WB_WRITE);
    wb_adr_o      = wb_we_o ? awaddr_q : araddr_q;
    wb_dat_o      = wdata_q;
    wb_sel_o      = (state_q == WB_READ) ? {SEL_BITS{1'b1}} : wstrb_q;
    bridge_err_o  = berr_q;
  end

endmodule

// File: doc/axil_to_wb_bridge.md
Name: axil_to_wb_bridge

Overview:
AXI4-Lite target to Wishbone classic master bridge. Lets an AXI4-Lite initiator, such as the PS or a debug master, reach the Wishbone register space. One transaction is in flight at a time. Each Wishbone access is bounded by a timeout, and error responses are flagged on bridge_err_o for an external sticky register.

Parameters:
ADDR_BITS, 18, address width on both interfaces (passed through unmodified)
DATA_BITS, 32, data width; sel/strb width is DATA_BITS/8
TIMEOUT, 255, wb_clk_i cycles to wait for ack/err/rty before aborting; 0 disables the timeout

Ports:
wb_clk_i  in  1  single clock for both interfaces
wb_rst_i  in  1  synchronous active-high reset
s_axi_awaddr/awvalid/awready  in/in/out  ADDR_BITS/1/1  AXI write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_BITS/DATA_BITS/8/1/1  AXI write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  AXI write response channel
s_axi_araddr/arvalid/arready  in/in/out  ADDR_BITS/1/1  AXI read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_BITS/2/1/1  AXI read data channel
wb_cyc_o/wb_stb_o/wb_we_o  out  1 each  Wishbone cycle, strobe, write-enable
wb_adr_o  out  ADDR_BITS  Wishbone address
wb_dat_o  out  DATA_BITS  Wishbone write data
wb_sel_o  out  DATA_BITS/8  Wishbone byte select
wb_dat_i  in  DATA_BITS  Wishbone read data
wb_ack_i/wb_err_i/wb_rty_i  in  1 each  Wishbone termination inputs
bridge_err_o  out  1  one-cycle pulse on any non-OKAY response

Behaviour:
- Reset values: all ready/valid outputs 0, cyc/stb/we 0, bresp/rresp 0, rdata 0, bridge_err_o 0, all held flags clear, round-robin bit 0 (write first).
- Channel capture:
  - awready = !aw_held && state==IDLE; wready = !w_held && state==IDLE; arready = !ar_held && state==IDLE.
  - On each handshake, the channel's address/data/strb is registered and its held flag is set.
  - AW and W may arrive in either order or in the same cycle.
  - An AR handshake may coincide with AW/W handshakes; all are captured.
- Grant (state IDLE): a write is eligible when aw_held && w_held; a read is eligible when ar_held.
  - If only one is eligible, it is granted.
  - If both are eligible, the round-robin bit selects; the bit toggles after every granted transaction.
  - The grant moves state to WB_WRITE or WB_READ on the next edge.
  - Latency: wb_cyc_o rises two clocks after the last required AXI handshake.
- States: IDLE -> WB_WRITE | WB_READ -> WRESP | RRESP -> IDLE.
- In WB_WRITE/WB_READ:
  - cyc_o = stb_o = 1; we_o = 1 for write.
  - adr/dat/sel are driven from the held registers and are stable for the whole cycle; sel = wstrb; sel is all-ones for reads.
  - The timeout counter clears on entry and increments each cycle.
- Termination, sampled in cycle k:
  - ack -> response OKAY (2'b00).
  - err or rty -> SLVERR (2'b10). Retry is not reissued.
  - Counter reaching TIMEOUT with no termination -> DECERR (2'b11).
  - Priority when several assert together: err > rty > ack.
- At edge k+1:
  - cyc_o/stb_o drop.
  - The response register loads, and bvalid or rvalid rises.
  - rdata = wb_dat_i on ack, and 0 on any error/timeout.
  - The consumed held flags clear.
  - bridge_err_o pulses high for exactly one cycle (k+1) if the response is not OKAY.
- WRESP/RRESP:
  - bvalid/rvalid and resp/rdata are held stable until bready/rready.
  - On the handshake edge, valid drops and state returns to IDLE.
  - A new WB cycle can start no earlier than two clocks later.
- A non-granted transaction stays held and is serviced after the current one, with no loss.
- Reset mid-operation: on the next edge cyc/stb drop and all valids and held flags clear. The in-flight transaction is discarded without a response.
- wb_dat_i is ignored outside ack cycles. Terminations outside WB_* states are ignored.

Test Plan:
- Write, AW and W in the same cycle (addr 0x00104, data 0xCAFEF00D, strb 0xF), slave acks after 3 cycles -> cyc_o high 2 clocks after the handshake with adr=0x00104, dat=0xCAFEF00D, sel=0xF, we=1; bvalid with bresp=00 one clock after ack; bridge_err_o stays 0.
- Read of 0x00200, slave acks with 0x12345678, rready held low 4 cycles -> rvalid=1, rdata=0x12345678, rresp=00, all stable until rready; returns to IDLE.
- W arrives 5 cycles before AW, strb=0x3 -> no WB cycle until AW arrives; then sel=0x3 and data matches the early W beat.
- AR, AW and W all handshake in the same cycle after reset -> write serviced first, then read; exactly two WB cycles; both responses delivered in that order.
- Read with slave silent, TIMEOUT=255 -> cyc_o high for exactly 256 cycles; rresp=11, rdata=0; bridge_err_o is a single-cycle pulse.
- err and rty asserted together on a write -> bresp=10 and bridge_err_o pulses; wb_rst_i asserted during a second WB cycle -> cyc_o=0 next clock, no bvalid, bridge accepts a new AW/W normally afterward.
